// File: rtl/fft_result_unloader.sv
// Snapshots completed FFT frames into a ping-pong buffer and streams them out one
// complex sample per valid/ready beat. Optional macro BITREV_EN: bit-reversed readout.
module fft_result_unloader #(
  parameter int W          = 16,
  parameter int LOG2N      = 5,
  parameter int LAST_STAGE = 4
) (
  input  logic                          clk2,
  input  logic                          rst,
  input  logic [2:0]                    stage_sel,
  input  logic [2*W*(1<<LOG2N)-1:0]     frame_in,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [W-1:0]                  out_re,
  output logic [W-1:0]                  out_im,
  output logic [LOG2N-1:0]              out_idx,
  output logic                          out_last,
  output logic                          frame_drop,
  output logic [7:0]                    drop_cnt,
  output logic                          busy
);
  // Handshake: a sample moves when out_valid && out_ready at a clk2 edge; while
  // out_valid is high and out_ready low, every output holds and out_valid stays high.

  localparam int N = 1 << LOG2N;
  localparam logic [2:0]       STAGE_LAST = 3'(LAST_STAGE);
  localparam logic [LOG2N-1:0] P_LAST     = LOG2N'(N - 1);

  logic [2*W-1:0] bank0 [N];
  logic [2*W-1:0] bank1 [N];

  logic             full0, full1;
  logic             rd_bank, wr_order;
  logic [2:0]       prev_stage;
  logic             capture, fire, rel0, rel1, free0, free1, wr0, wr1, drop;
  logic             ld, ld_bank;
  logic [LOG2N-1:0] ld_p, ld_entry;
  logic [2*W-1:0]   ld_sample;

  // A bank emptied by this cycle's final handshake may take this cycle's capture.
  always_comb begin
    capture = (stage_sel == STAGE_LAST) && (prev_stage != STAGE_LAST);
    fire    = out_valid && out_ready;
    rel0    = fire && out_last && !rd_bank;
    rel1    = fire && out_last && rd_bank;
    free0   = !full0 || rel0;
    free1   = !full1 || rel1;
    wr0     = capture && free0;
    wr1     = capture && free1 && !free0;
    drop    = capture && !free0 && !free1;
  end

  // Next sample to present; when idle with both banks full, the older is !wr_order.
  always_comb begin
    ld      = 1'b0;
    ld_bank = rd_bank;
    ld_p    = '0;
    if (out_valid) begin
      if (out_ready) begin
        if (!out_last) begin
          ld   = 1'b1;
          ld_p = out_idx + 1'b1;
        end else if (rd_bank ? full0 : full1) begin
          ld      = 1'b1;
          ld_bank = !rd_bank;
        end
      end
    end else if (full0 || full1) begin
      ld      = 1'b1;
      ld_bank = (full0 && full1) ? !wr_order : full1;
    end
  end

`ifdef BITREV_EN
  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
    return r;
  endfunction
  assign ld_entry = bitrev(ld_p);
`else
  assign ld_entry = ld_p;
`endif

  assign ld_sample = ld_bank ? bank1[ld_entry] : bank0[ld_entry];
  assign busy      = full0 | full1;

  // Buffer storage carries no reset; its contents only matter once a full flag is set.
  always_ff @(posedge clk2) begin
    for (int k = 0; k < N; k++) begin
      if (wr0) bank0[k] <= frame_in[2*W*k +: 2*W];
      if (wr1) bank1[k] <= frame_in[2*W*k +: 2*W];
    end
  end

  always_ff @(posedge clk2 or posedge rst) begin
    if (rst) begin
      prev_stage <= '0;
      full0      <= 1'b0;
      full1      <= 1'b0;
      rd_bank    <= 1'b0;
      wr_order   <= 1'b0;
      frame_drop <= 1'b0;
      drop_cnt   <= '0;
      out_valid  <= 1'b0;
      out_re     <= '0;
      out_im     <= '0;
      out_idx    <= '0;
      out_last   <= 1'b0;
    end else begin
      prev_stage <= stage_sel;
      full0      <= (full0 && !rel0) || wr0;
      full1      <= (full1 && !rel1) || wr1;
      if (wr0 || wr1) wr_order <= wr1;
      frame_drop <= drop;
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      if (ld) begin
        out_valid <= 1'b1;
        rd_bank   <= ld_bank;
        out_idx   <= ld_p;
        out_last  <= (ld_p == P_LAST);
        out_re    <= ld_sample[W-1:0];
        out_im    <= ld_sample[2*W-1:W];
      end else if (fire) begin
        out_valid <= 1'b0;
        out_idx   <= '0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule
